// File: rtl/tick_count_decoder.sv
// rtl/tick_count_decoder.sv - decodes a centisecond tick count into d/h/m/s/cs
//
// A sequential restoring divider runs four chained stages (/100, /60, /60, /24),
// one quotient bit per clock. The remainders of the stages become centiseconds,
// seconds, minutes and hours, and the final quotient becomes whole days.
// All result outputs load together on the edge that raises done.
//
// Optional feature macro: DISPLAY_BCD_EN (adds registered BCD copies of the
// centisecond, second, minute and hour fields).
//
// Ports:
//   clockSignal  in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   countIn      in   tick count, sampled on an accepted start
//   start        in   conversion request, accepted only while idle
//   busy         out  conversion in progress
//   done         out  one-cycle pulse, results updated on this edge
//   centisecOut  out  0..99
//   secOut       out  0..59
//   minOut       out  0..59
//   hourOut      out  0..23
//   dayOut       out  whole days (full quotient)
//   centisecBcd, secBcd, minBcd, hourBcd  out  {tens, ones} (DISPLAY_BCD_EN only)

module tick_count_decoder #(
    parameter int COUNT_W = 32
) (
    input  logic               clockSignal,
    input  logic               reset,
    input  logic [COUNT_W-1:0] countIn,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [6:0]         centisecOut,
    output logic [5:0]         secOut,
    output logic [5:0]         minOut,
    output logic [4:0]         hourOut,
`ifdef DISPLAY_BCD_EN
    output logic [7:0]         centisecBcd,
    output logic [7:0]         secBcd,
    output logic [7:0]         minBcd,
    output logic [7:0]         hourBcd,
`endif
    output logic [COUNT_W-1:0] dayOut
);

    localparam int BIT_W = (COUNT_W > 1) ? $clog2(COUNT_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(COUNT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] dividend_q, dividend_d;
    logic [7:0]         rem_q, rem_d;
    logic [1:0]         stage_q, stage_d;
    logic [BIT_W-1:0]   bit_q, bit_d;

    // Internal field registers filled stage by stage; hours are taken
    // straight from the last stage's remainder on the DONE-entry edge.
    logic [6:0]         cs_q, cs_d;
    logic [5:0]         sec_q, sec_d;
    logic [5:0]         min_q, min_d;

    logic [6:0]         out_cs_q, out_cs_d;
    logic [5:0]         out_sec_q, out_sec_d;
    logic [5:0]         out_min_q, out_min_d;
    logic [4:0]         out_hr_q, out_hr_d;
    logic [COUNT_W-1:0] out_day_q, out_day_d;

`ifdef DISPLAY_BCD_EN
    logic [7:0] bcd_cs_q, bcd_cs_d;
    logic [7:0] bcd_sec_q, bcd_sec_d;
    logic [7:0] bcd_min_q, bcd_min_d;
    logic [7:0] bcd_hr_q, bcd_hr_d;

    // Binary (<100) to {tens, ones} by comparing against multiples of ten.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'd0;
        for (int t = 1; t <= 9; t++) begin
            if (v >= 7'(t * 10)) begin
                tens = 4'(t);
            end
        end
        ones = 4'(v - 7'(tens) * 7'd10);
        return {tens, ones};
    endfunction
`endif

    // One restoring-division step on the current dividend/remainder.
    logic [7:0]         divisor;
    logic [8:0]         rem_shift;
    logic               q_bit;
    logic [7:0]         step_rem;
    logic [COUNT_W-1:0] step_quot;

    always_comb begin
        case (stage_q)
            2'd0:    divisor = 8'd100;
            2'd1:    divisor = 8'd60;
            2'd2:    divisor = 8'd60;
            default: divisor = 8'd24;
        endcase
        rem_shift = {rem_q, dividend_q[COUNT_W-1]};
        q_bit     = (rem_shift >= {1'b0, divisor});
        step_rem  = q_bit ? 8'(rem_shift - {1'b0, divisor}) : rem_shift[7:0];
        // The quotient bits shift into the vacated low end of the dividend,
        // so after COUNT_W steps the dividend register holds the quotient.
        step_quot = {dividend_q[COUNT_W-2:0], q_bit};
    end

    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        rem_d      = rem_q;
        stage_d    = stage_q;
        bit_d      = bit_q;
        cs_d       = cs_q;
        sec_d      = sec_q;
        min_d      = min_q;
        out_cs_d   = out_cs_q;
        out_sec_d  = out_sec_q;
        out_min_d  = out_min_q;
        out_hr_d   = out_hr_q;
        out_day_d  = out_day_q;
`ifdef DISPLAY_BCD_EN
        bcd_cs_d   = bcd_cs_q;
        bcd_sec_d  = bcd_sec_q;
        bcd_min_d  = bcd_min_q;
        bcd_hr_d   = bcd_hr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dividend_d = countIn;
                    rem_d      = 8'd0;
                    stage_d    = 2'd0;
                    bit_d      = LAST_BIT;
                    state_d    = S_DIV;
                end
            end
            S_DIV: begin
                dividend_d = step_quot;
                if (bit_q != '0) begin
                    rem_d = step_rem;
                    bit_d = bit_q - 1'b1;
                end else begin
                    // Stage boundary handled on the same edge: no bubble cycle.
                    rem_d   = 8'd0;
                    bit_d   = LAST_BIT;
                    stage_d = stage_q + 2'd1;
                    case (stage_q)
                        2'd0: cs_d  = step_rem[6:0];
                        2'd1: sec_d = step_rem[5:0];
                        2'd2: min_d = step_rem[5:0];
                        default: begin
                            out_cs_d  = cs_q;
                            out_sec_d = sec_q;
                            out_min_d = min_q;
                            out_hr_d  = step_rem[4:0];
                            out_day_d = step_quot;
`ifdef DISPLAY_BCD_EN
                            bcd_cs_d  = to_bcd(cs_q);
                            bcd_sec_d = to_bcd({1'b0, sec_q});
                            bcd_min_d = to_bcd({1'b0, min_q});
                            bcd_hr_d  = to_bcd({2'b00, step_rem[4:0]});
`endif
                            state_d   = S_DONE;
                        end
                    endcase
                end
            end
            S_DONE: begin
                // A start seen here is dropped; the block accepts it next cycle.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clockSignal or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            dividend_q <= '0;
            rem_q      <= 8'd0;
            stage_q    <= 2'd0;
            bit_q      <= '0;
            cs_q       <= 7'd0;
            sec_q      <= 6'd0;
            min_q      <= 6'd0;
            out_cs_q   <= 7'd0;
            out_sec_q  <= 6'd0;
            out_min_q  <= 6'd0;
            out_hr_q   <= 5'd0;
            out_day_q  <= '0;
`ifdef DISPLAY_BCD_EN
            bcd_cs_q   <= 8'h00;
            bcd_sec_q  <= 8'h00;
            bcd_min_q  <= 8'h00;
            bcd_hr_q   <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            rem_q      <= rem_d;
            stage_q    <= stage_d;
            bit_q      <= bit_d;
            cs_q       <= cs_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            out_cs_q   <= out_cs_d;
            out_sec_q  <= out_sec_d;
            out_min_q  <= out_min_d;
            out_hr_q   <= out_hr_d;
            out_day_q  <= out_day_d;
`ifdef DISPLAY_BCD_EN
            bcd_cs_q   <= bcd_cs_d;
            bcd_sec_q  <= bcd_sec_d;
            bcd_min_q  <= bcd_min_d;
            bcd_hr_q   <= bcd_hr_d;
`endif
        end
    end

    assign busy        = (state_q == S_DIV);
    assign done        = (state_q == S_DONE);
    assign centisecOut = out_cs_q;
    assign secOut      = out_sec_q;
    assign minOut      = out_min_q;
    assign hourOut     = out_hr_q;
    assign dayOut      = out_day_q;
`ifdef DISPLAY_BCD_EN
    assign centisecBcd = bcd_cs_q;
    assign secBcd      = bcd_sec_q;
    assign minBcd      = bcd_min_q;
    assign hourBcd     = bcd_hr_q;
`endif

endmodule

// File: tb/tb_tick_count_decoder.sv
// tb/tb_tick_count_decoder.sv - directed self-checking bench for tick_count_decoder

module tb_tick_count_decoder;

    logic        clockSignal;
    logic        reset;
    logic [31:0] countIn;
    logic        start;
    logic        busy;
    logic        done;
    logic [6:0]  centisecOut;
    logic [5:0]  secOut;
    logic [5:0]  minOut;
    logic [4:0]  hourOut;
    logic [31:0] dayOut;
`ifdef DISPLAY_BCD_EN
    logic [7:0]  centisecBcd;
    logic [7:0]  secBcd;
    logic [7:0]  minBcd;
    logic [7:0]  hourBcd;
`endif

    int errors   = 0;
    int checks   = 0;
    int n_edges  = 0;
    int busy_cnt = 0;
    int extra    = 0;

    tick_count_decoder #(.COUNT_W(32)) dut (
        .clockSignal (clockSignal),
        .reset       (reset),
        .countIn     (countIn),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .centisecOut (centisecOut),
        .secOut      (secOut),
        .minOut      (minOut),
        .hourOut     (hourOut),
`ifdef DISPLAY_BCD_EN
        .centisecBcd (centisecBcd),
        .secBcd      (secBcd),
        .minBcd      (minBcd),
        .hourBcd     (hourBcd),
`endif
        .dayOut      (dayOut)
    );

    initial clockSignal = 1'b0;
    always #5 clockSignal = ~clockSignal;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Issue a start (optionally from inside the done cycle, holding it until
    // accepted) and wait, bounded, for done. n_edges counts rising edges from
    // the accepting edge inclusive; busy_cnt counts cycles with busy high.
    task automatic run_conv(input logic [31:0] v, input bit in_done_cycle);
        int k;
        if (!in_done_cycle) @(negedge clockSignal);
        countIn = v;
        start   = 1'b1;
        k = 0;
        do begin
            @(posedge clockSignal);
            #1;
            k++;
        end while (!busy && k < 4);
        start    = 1'b0;
        n_edges  = 1;
        busy_cnt = 0;
        while (n_edges < 300) begin
            @(negedge clockSignal);
            if (busy) busy_cnt++;
            if (done) break;
            @(posedge clockSignal);
            n_edges++;
        end
    endtask

    task automatic check_res(input string tag, input int cs, input int s, input int m,
                             input int h, input int d);
        chk({tag, ".latency"}, 64'(n_edges), 64'd129);
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".cs"}, 64'(centisecOut), 64'(cs));
        chk({tag, ".sec"}, 64'(secOut), 64'(s));
        chk({tag, ".min"}, 64'(minOut), 64'(m));
        chk({tag, ".hour"}, 64'(hourOut), 64'(h));
        chk({tag, ".day"}, 64'(dayOut), 64'(d));
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        countIn = 32'd0;
        repeat (3) @(negedge clockSignal);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.cs", 64'(centisecOut), 64'd0);
        chk("rst.hour", 64'(hourOut), 64'd0);
        chk("rst.day", 64'(dayOut), 64'd0);
        reset = 1'b0;

        // Zero count: busy for exactly 128 cycles, done one cycle wide.
        run_conv(32'd0, 1'b0);
        check_res("zero", 0, 0, 0, 0, 0);
        chk("zero.busy_cycles", 64'(busy_cnt), 64'd128);
        chk("zero.busy_in_done", 64'(busy), 64'd0);
        @(negedge clockSignal);
        chk("zero.done_width", 64'(done), 64'd0);

        run_conv(32'd3723456, 1'b0);
        check_res("t1", 56, 34, 20, 10, 0);
`ifdef DISPLAY_BCD_EN
        chk("t1.secBcd", 64'(secBcd), 64'h34);
        chk("t1.csBcd", 64'(centisecBcd), 64'h56);
        chk("t1.minBcd", 64'(minBcd), 64'h20);
        chk("t1.hourBcd", 64'(hourBcd), 64'h10);
`endif

        // Back to back: second start raised during the done cycle.
        run_conv(32'd8639999, 1'b0);
        check_res("b2b_a", 99, 59, 59, 23, 0);
        run_conv(32'd8640000, 1'b1);
        check_res("b2b_b", 0, 0, 0, 0, 1);

        run_conv(32'hFFFF_FFFF, 1'b0);
        check_res("max", 95, 52, 27, 2, 497);

        // Input changes and a stray start during conversion have no effect.
        @(negedge clockSignal);
        countIn = 32'd100;
        start   = 1'b1;
        @(posedge clockSignal);
        #1;
        start   = 1'b0;
        n_edges = 1;
        while (n_edges < 300) begin
            @(negedge clockSignal);
            if (done) break;
            countIn = (n_edges == 50) ? 32'd999 : $urandom;
            start   = (n_edges == 50);
            @(posedge clockSignal);
            n_edges++;
        end
        start = 1'b0;
        check_res("noisy", 0, 1, 0, 0, 0);
        extra = 0;
        repeat (200) begin
            @(negedge clockSignal);
            if (done) extra++;
        end
        chk("noisy.second_done", 64'(extra), 64'd0);

        // Reset in the middle of a conversion after a result is held.
        run_conv(32'd3723456, 1'b0);
        check_res("pre_rst", 56, 34, 20, 10, 0);
        @(negedge clockSignal);
        countIn = 32'd3723456;
        start   = 1'b1;
        @(posedge clockSignal);
        #1;
        start = 1'b0;
        repeat (69) @(posedge clockSignal);
        @(negedge clockSignal);
        reset = 1'b1;
        #1;
        chk("midrst.busy", 64'(busy), 64'd0);
        chk("midrst.done", 64'(done), 64'd0);
        chk("midrst.cs", 64'(centisecOut), 64'd0);
        chk("midrst.sec", 64'(secOut), 64'd0);
        chk("midrst.min", 64'(minOut), 64'd0);
        chk("midrst.hour", 64'(hourOut), 64'd0);
        chk("midrst.day", 64'(dayOut), 64'd0);
        @(negedge clockSignal);
        reset = 1'b0;
        extra = 0;
        repeat (200) begin
            @(negedge clockSignal);
            if (done) extra++;
        end
        chk("midrst.no_done", 64'(extra), 64'd0);

        run_conv(32'd3723456, 1'b0);
        check_res("post_rst", 56, 34, 20, 10, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
